// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the sequential restoring divider:
//                FSM state encoding, default operand width and the
//                iteration-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    // Default operand / quotient / remainder width
    localparam int C_DEFAULT_WIDTH = 16;

    // Controller states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence one extra bit
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_trial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : div_trial_sub
//  Description : N-bit trial subtractor (a - b) built as an adder with the
//                B operand inverted and carry-in tied to one. Borrow is the
//                inverted carry-out.
//  Revision    : 1.0  initial release
// ============================================================================
module div_trial_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    logic [N:0] w_sum;

    // a + ~b + 1 with one extra bit to capture the carry-out
    assign w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + (N+1)'(1);
    assign o_diff   = w_sum[N-1:0];
    assign o_borrow = ~w_sum[N];

endmodule : div_trial_sub
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Multi-cycle restoring divider, one quotient bit per clock,
//                start/busy/done handshake. Divide-by-zero bypasses the
//                iteration and completes on the cycle after acceptance.
//                Optional macro DIV_SIGNED_EN: two's-complement operands,
//                truncation toward zero (remainder takes dividend's sign).
//  Revision    : 1.0  initial release
// ============================================================================
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next_state;

    // Partial remainder A always stays below M after each step, so WIDTH bits
    // suffice for storage; the shifted value used for the trial is WIDTH+1.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shift_a;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_restore;
    logic [WIDTH-1:0] w_new_a;
    logic [WIDTH-1:0] w_new_q;
    logic [WIDTH-1:0] w_mag_dvd;
    logic [WIDTH-1:0] w_mag_dvs;
    logic [WIDTH-1:0] w_fin_q;
    logic [WIDTH-1:0] w_fin_r;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_count == CNT_W'(1));

    // Shift {A,Q} left one place and trial-subtract the divisor
    assign w_shift_a = {r_a, r_q[WIDTH-1]};

    div_trial_sub #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .i_a      (w_shift_a),
        .i_b      ({1'b0, r_m}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // A negative trial shows both as a borrow and as a set MSB; either restores
    assign w_restore = w_borrow | w_diff[WIDTH];
    assign w_new_a   = w_restore ? w_shift_a[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_new_q   = {r_q[WIDTH-2:0], ~w_restore};

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Operate on magnitudes; most-negative maps onto itself as unsigned
    assign w_mag_dvd = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign w_mag_dvs = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    assign w_fin_q   = r_neg_q ? (~w_new_q + WIDTH'(1)) : w_new_q;
    assign w_fin_r   = r_neg_r ? (~w_new_a + WIDTH'(1)) : w_new_a;

    // Latch operand signs for the result correction at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept && !w_div_zero) begin
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign w_mag_dvd = dividend;
    assign w_mag_dvs = divisor;
    assign w_fin_q   = w_new_q;
    assign w_fin_r   = w_new_a;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = w_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand load, one iteration per RUN cycle, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_div_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= dividend;
                    r_dbz       <= 1'b1;
                end else begin
                    r_a     <= '0;
                    r_q     <= w_mag_dvd;
                    r_m     <= w_mag_dvs;
                    r_count <= CNT_W'(WIDTH);
                    r_dbz   <= 1'b0;
                end
            end else if (r_state == RUN) begin
                r_a     <= w_new_a;
                r_q     <= w_new_q;
                r_count <= r_count - CNT_W'(1);
                if (w_last) begin
                    r_quotient  <= w_fin_q;
                    r_remainder <= w_fin_r;
                end
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule : seq_restoring_divider
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_divider
//  Description : Self-checking bench for seq_restoring_divider: directed
//                cases plus randomized operands against an arithmetic
//                reference model (signed model when DIV_SIGNED_EN is set).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks;
    int n_fail;

    seq_restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic division
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
            z = 1'b0;
        end
    endtask

    // One full operation; glitch_at >= 0 pulses a second start mid-run
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch_at);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           n;
        logic         busy_bad;
        model(a, b, eq, er, ez);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        n        = 0;
        busy_bad = 1'b0;
        while (!done && n < W + 4) begin
            if (!busy) busy_bad = 1'b1;
            if (n == glitch_at) begin
                start    = 1'b1;
                dividend = W'(50);
                divisor  = W'(5);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency", n, (b == '0) ? 0 : W);
        check("busy_during_run", busy_bad, 0);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        // start while in DONE must be ignored
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_cleared", done, 0);
        check("start_in_done_ignored", busy, 0);
        @(posedge clk);
        #1;
        check("quotient_held", quotient, eq);
        check("remainder_held", remainder, er);
    endtask

    initial begin
        logic         saw_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(W'(100), W'(7), -1);
        run_op(W'(16'hFFFF), W'(1), -1);
        run_op(W'(3), W'(10), -1);
        run_op(W'(5), W'(0), -1);
        run_op(W'(9), W'(3), -1);
        run_op(W'(1000), W'(9), 3);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(1000);
        divisor  = W'(9);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_quotient", quotient, 0);
        check("arst_remainder", remainder, 0);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_rst", saw_done, 0);
        run_op(W'(40), W'(6), -1);

`ifdef DIV_SIGNED_EN
        run_op(W'(16'hFF9C), W'(7), -1);
        run_op(W'(16'h8000), W'(16'hFFFF), -1);
`endif

        // Randomized operands with a mix of divisor shapes
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = W'($urandom);
                default: rb = ra >> $urandom_range(0, W - 1);
            endcase
            run_op(ra, rb, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_restoring_divider
`default_nettype wire
